plot_sink: RTL and testbench

- Consumer end of the pixel-plot stream (x, y, color, plot) driven by the drawer/sequencer modules.
- Converts each plot strobe into a linear framebuffer write for a 320x240, 3-bit-colour framebuffer.
- Absorbs bursts in a small FIFO and drains it through a shared memory write port whose ready signal may stall.
- Exposes busy/overflow status so sequencers can wait before issuing the next go.

---
 rtl/plot_sink_pkg.sv | 24 ++
 rtl/plot_sink_if.sv | 24 ++
 rtl/plot_sink_fifo.sv | 55 +++++
 rtl/plot_sink.sv | 155 +++++++++++++++
 tb/tb_plot_sink.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_sink_pkg.sv
// Shared constants, clear-FSM state type and address helper for the plot_sink pixel consumer.
package plot_sink_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;
    localparam int COLOR_W  = 3;
    localparam int FB_WORDS = 76800;
    localparam int ENTRY_W  = ADDR_W + COLOR_W;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    // y*320 + x as two shifts and an add; y*320 = y*256 + y*64
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = {9'd0, y};
        return (y_ext << 8) + (y_ext << 6) + {8'd0, x};
    endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Pixel-plot stream and framebuffer write port seen by plot_sink (slave) and its driver (master).
interface plot_sink_if;
    import plot_sink_pkg::*;

    logic [8:0]         x_in;
    logic [7:0]         y_in;
    logic [COLOR_W-1:0] color_in;
    logic               plot_in;
    logic               mem_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;

    modport master (
        output x_in, y_in, color_in, plot_in, mem_ready,
        input  mem_we, mem_addr, mem_data
    );

    modport slave (
        input  x_in, y_in, color_in, plot_in, mem_ready,
        output mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/plot_sink_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module plot_sink_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/plot_sink.sv
// Pixel-plot sink: sample, compute linear address, buffer, drain to framebuffer port.
// Optional framebuffer clear engine compiled in with PLOT_SINK_FB_CLEAR_EN.
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CLIP_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    plot_sink_if.slave         bus,
    input  logic               clear_flags,
`ifdef PLOT_SINK_FB_CLEAR_EN
    input  logic               clear_go,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_done,
`endif
    output logic               busy,
    output logic               overflow,
    output logic [CLIP_W-1:0]  clip_count
);

    logic               in_range;
    logic               clip_evt;
    logic               s1_valid;
    logic [8:0]         s1_x;
    logic [7:0]         s1_y;
    logic [COLOR_W-1:0] s1_color;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               fifo_pop;
    logic               clearing;

    assign in_range = (bus.x_in < 9'(SCREEN_W)) && (bus.y_in < 8'(SCREEN_H));
    assign clip_evt = bus.plot_in && !in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_color <= '0;
        end else begin
            s1_valid <= bus.plot_in && in_range;
            s1_x     <= bus.x_in;
            s1_y     <= bus.y_in;
            s1_color <= bus.color_in;
        end
    end

    // A new event in the same cycle as clear_flags wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (clip_evt)
                clip_count <= clear_flags ? CLIP_W'(1) :
                              (&clip_count ? clip_count : clip_count + 1'b1);
            else if (clear_flags)
                clip_count <= '0;

            if (fifo_drop)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;
        end
    end

    assign push_data = {pix_addr(s1_x, s1_y), s1_color};
    assign fifo_pop  = !clearing && !fifo_empty && bus.mem_ready;

    plot_sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s1_valid),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

`ifdef PLOT_SINK_FB_CLEAR_EN
    // state     | meaning
    // CLR_IDLE  | port owned by the FIFO, waiting for clear_go
    // CLR_CLEAR | sweeping addresses 0..FB_WORDS-1 with the latched colour
    // CLR_DONE  | one-cycle clear_done pulse, then back to idle
    clr_state_t         clr_state;
    clr_state_t         clr_next;
    logic [ADDR_W-1:0]  clr_addr;
    logic [COLOR_W-1:0] clr_color_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_state   <= CLR_IDLE;
            clr_addr    <= '0;
            clr_color_q <= '0;
        end else begin
            clr_state <= clr_next;
            if (clr_state == CLR_IDLE && clear_go) begin
                clr_addr    <= '0;
                clr_color_q <= clear_color;
            end else if (clr_state == CLR_CLEAR && bus.mem_ready) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        clr_next   = clr_state;
        clear_done = 1'b0;
        case (clr_state)
            CLR_IDLE:  if (clear_go) clr_next = CLR_CLEAR;
            CLR_CLEAR: if (bus.mem_ready && clr_addr == ADDR_W'(FB_WORDS - 1)) clr_next = CLR_DONE;
            CLR_DONE: begin
                clear_done = 1'b1;
                clr_next   = CLR_IDLE;
            end
            default:   clr_next = CLR_IDLE;
        endcase
    end

    assign clearing = (clr_state == CLR_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    always_comb begin
        bus.mem_we   = !fifo_empty;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (!fifo_empty) begin
            bus.mem_addr = fifo_head[ENTRY_W-1:COLOR_W];
            bus.mem_data = fifo_head[COLOR_W-1:0];
        end
`ifdef PLOT_SINK_FB_CLEAR_EN
        if (clearing) begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = clr_addr;
            bus.mem_data = clr_color_q;
        end
`endif
    end

    assign busy = s1_valid || !fifo_empty || clearing;

endmodule

// File: tb/tb_plot_sink.sv
// Scoreboard bench for plot_sink: occupancy/queue reference model, decoupled write monitor.
module tb_plot_sink;

    localparam int DEPTH  = 8;
    localparam int CLIP_W = 8;
    localparam int CLIP_MAX = (1 << CLIP_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              clear_flags = 1'b0;
    logic              busy;
    logic              overflow;
    logic [CLIP_W-1:0] clip_count;
`ifdef PLOT_SINK_FB_CLEAR_EN
    logic              clear_go = 1'b0;
    logic [2:0]        clear_color = 3'd0;
    logic              clear_done;
`endif

    plot_sink_if bus ();

    plot_sink #(.DEPTH(DEPTH), .CLIP_W(CLIP_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .clear_flags (clear_flags),
`ifdef PLOT_SINK_FB_CLEAR_EN
        .clear_go    (clear_go),
        .clear_color (clear_color),
        .clear_done  (clear_done),
`endif
        .busy        (busy),
        .overflow    (overflow),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_wr = 0;
    int  last_addr = -1;

    // reference model state
    int  m_occ = 0;
    bit  m_pend = 0;
    wr_t m_pend_w;
    bit  m_ovf = 0;
    int  m_clip = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: advance one clock edge using the inputs the DUT is about to sample.
    initial forever begin
        @(negedge clk);
        #2;
        if (!reset_n) begin
            m_occ  = 0;
            m_pend = 0;
            m_ovf  = 0;
            m_clip = 0;
            exp_q.delete();
        end else begin
            bit pop, ovf_evt, clip_evt, inr;
            int x, y;
            pop     = (m_occ > 0) && bus.mem_ready;
            ovf_evt = 0;
            if (m_pend) begin
                if (m_occ < DEPTH || pop) begin
                    exp_q.push_back(m_pend_w);
                    m_occ++;
                end else begin
                    ovf_evt = 1;
                end
            end
            if (pop) m_occ--;
            x = int'(bus.x_in);
            y = int'(bus.y_in);
            inr = (x < 320) && (y < 240);
            clip_evt = bus.plot_in && !inr;
            if (ovf_evt) m_ovf = 1;
            else if (clear_flags) m_ovf = 0;
            if (clip_evt) m_clip = clear_flags ? 1 : ((m_clip == CLIP_MAX) ? CLIP_MAX : m_clip + 1);
            else if (clear_flags) m_clip = 0;
            m_pend = bus.plot_in && inr;
            m_pend_w.addr = y * 320 + x;
            m_pend_w.data = int'(bus.color_in);
        end
    end

    // Monitor: whatever the DUT presents must be the oldest outstanding pixel.
    initial forever begin
        @(negedge clk);
        #1;
        if (reset_n) begin
            chk("mem_we", int'(bus.mem_we), (m_occ > 0) ? 1 : 0);
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write", bus.mem_addr, bus.mem_data);
                end else begin
                    chk("wr_addr", int'(bus.mem_addr), exp_q[0].addr);
                    chk("wr_data", int'(bus.mem_data), exp_q[0].data);
                    if (bus.mem_ready) begin
                        void'(exp_q.pop_front());
                        n_wr++;
                        last_addr = int'(bus.mem_addr);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic plot_px(input int x, input int y, input int c);
        bus.x_in     = 9'(x);
        bus.y_in     = 8'(y);
        bus.color_in = 3'(c);
        bus.plot_in  = 1'b1;
        @(negedge clk);
        bus.plot_in  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #3;
            if (!busy && !m_pend && m_occ == 0 && exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk({name, "_drained"}, int'(done), 1);
        chk({name, "_overflow"}, int'(overflow), int'(m_ovf));
        chk({name, "_clip"}, int'(clip_count), m_clip);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    initial begin
        int w0;
        bus.x_in = '0; bus.y_in = '0; bus.color_in = '0; bus.plot_in = 1'b0; bus.mem_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_clip", int'(clip_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // single pixel: write appears after E1, completes at E2
        plot_px(5, 2, 3);
        #1 chk("lat_we_before_e1", int'(bus.mem_we), 0);
        @(negedge clk);
        #1;
        chk("single_we", int'(bus.mem_we), 1);
        chk("single_addr", int'(bus.mem_addr), 645);
        chk("single_data", int'(bus.mem_data), 3);
        @(negedge clk);
        #1 chk("single_busy_falls", int'(busy), 0);
        @(negedge clk);
        wait_idle("single");

        // burst along row 0
        w0 = n_wr;
        for (int i = 0; i < 20; i++) plot_px(i, 0, i % 8);
        wait_idle("burst");
        chk("burst_writes", n_wr - w0, 20);
        chk("burst_last_addr", last_addr, 19);
        chk("burst_no_ovf", int'(overflow), 0);

        // stall: only DEPTH of 12 survive
        w0 = n_wr;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) plot_px($urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 7));
        repeat (4) @(negedge clk);
        #1 chk("stall_ovf", int'(overflow), 1);
        chk("stall_no_writes", n_wr - w0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        wait_idle("stall");
        chk("stall_writes", n_wr - w0, DEPTH);
        pulse_clear();
        #1 chk("stall_ovf_cleared", int'(overflow), 0);
        @(negedge clk);

        // clipping edges
        w0 = n_wr;
        plot_px(320, 0, 1);
        plot_px(0, 240, 2);
        plot_px(319, 239, 5);
        wait_idle("clip");
        chk("clip_count", int'(clip_count), 2);
        chk("clip_writes", n_wr - w0, 1);
        chk("clip_last_addr", last_addr, 76799);
        pulse_clear();

        // full FIFO with push and pop on the same edge
        w0 = n_wr;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) plot_px(i, 10, 1);
        repeat (2) @(negedge clk);
        plot_px(100, 10, 2);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) plot_px(101 + i, 10, 3);
        wait_idle("fullpp");
        chk("fullpp_no_ovf", int'(overflow), 0);
        chk("fullpp_writes", n_wr - w0, DEPTH + 10);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            clear_flags   = ($urandom_range(0, 15) == 0);
            bus.x_in      = 9'($urandom_range(0, 335));
            bus.y_in      = 8'($urandom_range(0, 250));
            bus.color_in  = 3'($urandom_range(0, 7));
            bus.plot_in   = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        bus.plot_in = 1'b0;
        clear_flags = 1'b0;
        bus.mem_ready = 1'b1;
        wait_idle("random");
        pulse_clear();

        // reset in the middle of a stalled, overflowing burst
        bus.mem_ready = 1'b0;
        plot_px(400, 0, 1);
        for (int i = 0; i < 10; i++) plot_px(i, 20, 4);
        #1 chk("pre_rst_ovf", int'(overflow), 1);
        @(negedge clk);
        reset_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("mid_rst_mem_we", int'(bus.mem_we), 0);
        chk("mid_rst_addr", int'(bus.mem_addr), 0);
        chk("mid_rst_data", int'(bus.mem_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_clip", int'(clip_count), 0);
        w0 = n_wr;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_writes", n_wr - w0, 0);
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
